// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and a per-register busy scoreboard
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit READ_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0]           rd_en_i,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_i,
    output logic [NRD*XLEN-1:0]      rd_data_o,
    output logic [NRD-1:0]           rd_busy_o,
    input  logic [NWR-1:0]           wr_en_i,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_addr_i,
    input  logic [NWR*XLEN-1:0]      wr_data_i,
    input  logic                     alloc_en_i,
    input  logic [$clog2(NREGS)-1:0] alloc_addr_i,
    input  logic                     flush_i
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_nxt;
    logic [NRD-1:0][XLEN-1:0]   rd_val;
    logic [NRD-1:0]             rd_bsy;

    // register array update; later ports overwrite earlier ones on an address clash
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) regs <= '0;
        else
            for (int w = 0; w < NWR; w++)
                if (wr_en_i[w] && !(ZERO_REG && wr_addr_i[w*AW +: AW] == '0))
                    regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];

    // scoreboard next state: flush beats alloc, alloc beats write-clear
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NWR; w++)
            if (wr_en_i[w]) busy_nxt[wr_addr_i[w*AW +: AW]] = 1'b0;
        if (alloc_en_i) busy_nxt[alloc_addr_i] = 1'b1;
        if (flush_i) busy_nxt = '0;
        if (ZERO_REG) busy_nxt[0] = 1'b0;
    end

    // scoreboard state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy <= '0;
        else busy <= busy_nxt;

    // read value per port with bypass from same-cycle writes
    always_comb begin
        rd_val = '0;
        rd_bsy = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_val[p] = regs[rd_addr_i[p*AW +: AW]];
            for (int w = 0; w < NWR; w++)
                if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])
                    rd_val[p] = wr_data_i[w*XLEN +: XLEN];
            if (ZERO_REG && rd_addr_i[p*AW +: AW] == '0) rd_val[p] = '0;
            rd_bsy[p] = busy_nxt[rd_addr_i[p*AW +: AW]];
        end
    end

    generate
        if (READ_REG) begin : g_reg
            // registered read outputs, each port holds while its enable is low
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    rd_data_o <= '0;
                    rd_busy_o <= '0;
                end else
                    for (int p = 0; p < NRD; p++)
                        if (rd_en_i[p]) begin
                            rd_data_o[p*XLEN +: XLEN] <= rd_val[p];
                            rd_busy_o[p]              <= rd_bsy[p];
                        end
        end else begin : g_comb
            logic unused_rd_en;
            assign unused_rd_en = ^rd_en_i;
            assign rd_data_o    = rd_val;
            assign rd_busy_o    = rd_bsy;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of a registered 2R/2W and a combinational 3R/1W register file
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   a_rd_en;
    logic [9:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_busy;
    logic [1:0]   a_wr_en;
    logic [9:0]   a_wr_addr;
    logic [63:0]  a_wr_data;
    logic         a_alloc_en;
    logic [4:0]   a_alloc_addr;
    logic         a_flush;

    logic [2:0]   b_rd_en;
    logic [14:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic [0:0]   b_wr_en;
    logic [4:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_alloc_en;
    logic [4:0]   b_alloc_addr;
    logic         b_flush;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1'b1), .READ_REG(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data),
        .rd_busy_o(a_rd_busy), .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
        .alloc_en_i(a_alloc_en), .alloc_addr_i(a_alloc_addr), .flush_i(a_flush));

    regfile_mp #(.XLEN(64), .NREGS(32), .NRD(3), .NWR(1), .ZERO_REG(1'b1), .READ_REG(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data),
        .rd_busy_o(b_rd_busy), .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
        .alloc_en_i(b_alloc_en), .alloc_addr_i(b_alloc_addr), .flush_i(b_flush));

    // behavioural model: register contents, busy bits, expected registered outputs of dut_a
    logic [31:0] ma [32];
    logic [63:0] mb [32];
    bit          ba [32];
    bit          bb [32];
    logic [31:0] ea_d [2];
    bit          ea_b [2];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdval_a(input int a);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = ma[a];
        for (int w = 0; w < 2; w++)
            if (a_wr_en[w] && int'(a_wr_addr[w*5 +: 5]) == a) v = a_wr_data[w*32 +: 32];
        return v;
    endfunction

    function automatic bit nb_a(input int r);
        bit wr_hit = 1'b0;
        for (int w = 0; w < 2; w++)
            if (a_wr_en[w] && int'(a_wr_addr[w*5 +: 5]) == r) wr_hit = 1'b1;
        if (r == 0 || a_flush) return 1'b0;
        if (a_alloc_en && int'(a_alloc_addr) == r) return 1'b1;
        return wr_hit ? 1'b0 : ba[r];
    endfunction

    function automatic logic [63:0] rdval_b(input int a);
        if (a == 0) return 64'h0;
        if (b_wr_en[0] && int'(b_wr_addr) == a) return b_wr_data;
        return mb[a];
    endfunction

    function automatic bit nb_b(input int r);
        if (r == 0 || b_flush) return 1'b0;
        if (b_alloc_en && int'(b_alloc_addr) == r) return 1'b1;
        if (b_wr_en[0] && int'(b_wr_addr) == r) return 1'b0;
        return bb[r];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            ma[r] = '0; mb[r] = '0; ba[r] = 1'b0; bb[r] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            ea_d[p] = '0; ea_b[p] = 1'b0;
        end
    endtask

    task automatic check_b();
        for (int p = 0; p < 3; p++) begin
            chk("b_data", b_rd_data[p*64 +: 64], rdval_b(int'(b_rd_addr[p*5 +: 5])));
            chk("b_busy", 64'(b_rd_busy[p]), 64'(nb_b(int'(b_rd_addr[p*5 +: 5]))));
        end
    endtask

    // one clock: check combinational dut_b, advance model, check registered dut_a
    task automatic tick();
        bit nba [32];
        bit nbb [32];
        #1;
        check_b();
        for (int p = 0; p < 2; p++)
            if (a_rd_en[p]) begin
                ea_d[p] = rdval_a(int'(a_rd_addr[p*5 +: 5]));
                ea_b[p] = nb_a(int'(a_rd_addr[p*5 +: 5]));
            end
        for (int r = 0; r < 32; r++) begin
            nba[r] = nb_a(r); nbb[r] = nb_b(r);
        end
        for (int r = 0; r < 32; r++) begin
            ba[r] = nba[r]; bb[r] = nbb[r];
        end
        for (int w = 0; w < 2; w++)
            if (a_wr_en[w] && a_wr_addr[w*5 +: 5] != 5'd0) ma[a_wr_addr[w*5 +: 5]] = a_wr_data[w*32 +: 32];
        if (b_wr_en[0] && b_wr_addr != 5'd0) mb[b_wr_addr] = b_wr_data;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            chk("a_data", 64'(a_rd_data[p*32 +: 32]), 64'(ea_d[p]));
            chk("a_busy", 64'(a_rd_busy[p]), 64'(ea_b[p]));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        a_rd_en = '0; a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
        a_alloc_en = 1'b0; a_alloc_addr = '0; a_flush = 1'b0;
        b_rd_en = '0; b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
        b_alloc_en = 1'b0; b_alloc_addr = '0; b_flush = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_a_data", a_rd_data, 64'h0);
        chk("rst_a_busy", 64'(a_rd_busy), 64'h0);
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            a_rd_en = 2'b11; a_rd_addr = {5'(a), 5'(a)}; b_rd_addr = {5'(a), 5'(a), 5'(a)};
            tick();
            chk("t1_a_data", a_rd_data, 64'h0);
            chk("t1_a_busy", 64'(a_rd_busy), 64'h0);
            chk("t1_b_data", b_rd_data[63:0], 64'h0);
        end

        idle();
        a_wr_en = 2'b01; a_wr_addr = 10'd5; a_wr_data = 64'hDEADBEEF;
        b_wr_en = 1'b1; b_wr_addr = 5'd5; b_wr_data = 64'hDEADBEEF;
        tick();
        idle();
        a_rd_en = 2'b01; a_rd_addr = 10'd5; b_rd_addr = 15'd5;
        tick();
        chk("t2_a_data", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
        chk("t2_b_data", b_rd_data[63:0], 64'hDEADBEEF);

        idle();
        a_rd_en = 2'b11; a_rd_addr = {5'd0, 5'd7};
        a_wr_en = 2'b11; a_wr_addr = {5'd0, 5'd7}; a_wr_data = {32'hFFFFFFFF, 32'h1234};
        b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 64'h1234; b_rd_addr = {5'd0, 5'd0, 5'd7};
        #1;
        chk("t3_b_bypass", b_rd_data[63:0], 64'h1234);
        tick();
        chk("t3_a_bypass", 64'(a_rd_data[31:0]), 64'h1234);
        chk("t3_a_x0", 64'(a_rd_data[63:32]), 64'h0);
        b_wr_addr = 5'd0; b_wr_data = 64'hFFFFFFFF_FFFFFFFF;
        #1;
        chk("t3_b_x0", b_rd_data[127:64], 64'h0);
        tick();

        idle();
        a_wr_en = 2'b11; a_wr_addr = {5'd3, 5'd3}; a_wr_data = {32'h5555, 32'hAAAA};
        tick();
        idle();
        a_rd_en = 2'b10; a_rd_addr = {5'd3, 5'd0};
        tick();
        chk("t4_a_x3", 64'(a_rd_data[63:32]), 64'h5555);

        idle();
        a_rd_en = 2'b01; a_rd_addr = 10'd9; a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
        b_rd_addr = 15'd9; b_alloc_en = 1'b1; b_alloc_addr = 5'd9;
        #1;
        chk("t5_b_alloc", 64'(b_rd_busy[0]), 64'h1);
        tick();
        chk("t5_a_alloc", 64'(a_rd_busy[0]), 64'h1);
        a_alloc_en = 1'b0; a_wr_en = 2'b01; a_wr_addr = 10'd9; a_wr_data = 64'h42;
        b_alloc_en = 1'b0; b_wr_en = 1'b1; b_wr_addr = 5'd9; b_wr_data = 64'h42;
        #1;
        chk("t5_b_wrbusy", 64'(b_rd_busy[0]), 64'h0);
        chk("t5_b_wrdata", b_rd_data[63:0], 64'h42);
        tick();
        chk("t5_a_wrbusy", 64'(a_rd_busy[0]), 64'h0);
        chk("t5_a_wrdata", 64'(a_rd_data[31:0]), 64'h42);
        a_alloc_en = 1'b1; b_alloc_en = 1'b1;
        #1;
        chk("t5_b_both", 64'(b_rd_busy[0]), 64'h1);
        tick();
        chk("t5_a_both", 64'(a_rd_busy[0]), 64'h1);
        a_wr_en = '0; a_flush = 1'b1; b_wr_en = '0; b_flush = 1'b1;
        #1;
        chk("t5_b_flush", 64'(b_rd_busy[0]), 64'h0);
        tick();
        chk("t5_a_flush", 64'(a_rd_busy[0]), 64'h0);

        for (int i = 0; i < 600; i++) begin
            a_rd_en = 2'($urandom_range(0, 3));
            a_wr_en = 2'($urandom_range(0, 3));
            a_wr_data = {$urandom, $urandom};
            a_alloc_en = ($urandom_range(0, 2) == 0);
            a_alloc_addr = 5'($urandom_range(0, 15));
            a_flush = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 2; p++) begin
                a_rd_addr[p*5 +: 5] = 5'($urandom_range(0, 15));
                a_wr_addr[p*5 +: 5] = 5'($urandom_range(0, 15));
            end
            b_rd_en = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) b_rd_addr[p*5 +: 5] = 5'($urandom_range(0, 15));
            b_wr_en = 1'($urandom_range(0, 1));
            b_wr_addr = 5'($urandom_range(0, 15));
            b_wr_data = {$urandom, $urandom};
            b_alloc_en = ($urandom_range(0, 2) == 0);
            b_alloc_addr = 5'($urandom_range(0, 15));
            b_flush = ($urandom_range(0, 15) == 0);
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                chk("rst_mid_a_data", a_rd_data, 64'h0);
                chk("rst_mid_a_busy", 64'(a_rd_busy), 64'h0);
                check_b();
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
